// File: rtl/vp_tag_checker.sv
// vp_tag_checker: passes the tagged video stream through with one cycle of delay.
// It validates the per-line frame tags, checks tag sequence and line geometry, and keeps sticky error flags.
module vp_tag_checker #(
    parameter int TAG_LEN   = 20,
    parameter int EXP_PIX   = 1280,
    parameter int EXP_LINES = 480
) (
    input  logic        vpclkin,
    input  logic        nReset,
    input  logic [9:0]  din,
    input  logic        href,
    input  logic        vsync,
    input  logic        clr_err,
    output logic [9:0]  dout,
    output logic        href_o,
    output logic        vsync_o,
    output logic [7:0]  frame_tag,
    output logic        tag_valid,
    output logic [10:0] last_pix,
    output logic [9:0]  last_lines,
    output logic        frame_done,
    output logic        err_tag,
    output logic        err_seq,
    output logic        err_len
);
    localparam logic [10:0] TL = 11'(TAG_LEN);
    localparam logic [10:0] EP = 11'(EXP_PIX);
    localparam logic [9:0]  EL = 10'(EXP_LINES);

    typedef enum logic [1:0] {IDLE, GAP, TAG, DATA} state_t;
    state_t state, nxt;

    logic        href_q, vsync_q, have_cur, seeded;
    logic [10:0] pix_cnt, inc, len, idx;
    logic [9:0]  line_cnt, lc_eff;
    logic [7:0]  line_tag, cur_tag, prev_tag, cur_eff;
    logic        ls, le, fs, do_le, good_le, tag_pix, do_fe;
    logic        new_tag, new_seq, new_len;

    assign href_o  = href_q;
    assign vsync_o = vsync_q;

    always_comb begin
        ls      = href & ~href_q;
        le      = ~href & href_q;
        fs      = vsync & ~vsync_q;
        inc     = &pix_cnt ? pix_cnt : pix_cnt + 11'd1;
        // a line cut short by vsync still owns the current href-high cycle
        len     = href ? inc : pix_cnt;
        idx     = ls ? 11'd0 : pix_cnt;
        do_le   = (state == TAG || state == DATA) & (le | fs);
        good_le = do_le & (len >= TL);
        tag_pix = href & ((state == GAP & ls) | state == TAG);
        cur_eff = (good_le & ~have_cur) ? line_tag : cur_tag;
        lc_eff  = do_le ? (&line_cnt ? line_cnt : line_cnt + 10'd1) : line_cnt;
        do_fe   = fs & (lc_eff != 10'd0);
        new_tag = (tag_pix & ((din[1:0] != 2'd0) | (idx != 11'd0 & din[9:2] != line_tag)))
                | (good_le & have_cur & line_tag != cur_tag);
        new_len = (do_le & len != EP) | (do_fe & lc_eff != EL);
        new_seq = do_fe & seeded & (cur_eff != prev_tag + 8'd1);
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = fs ? GAP : IDLE;
            GAP:     nxt = ls ? ((11'd1 >= TL) ? DATA : TAG) : GAP;
            TAG:     nxt = (fs | le) ? GAP : (inc >= TL) ? DATA : TAG;
            DATA:    nxt = (fs | le) ? GAP : DATA;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge vpclkin or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            dout       <= '0;
            href_q     <= 1'b0;
            vsync_q    <= 1'b0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            line_tag   <= '0;
            cur_tag    <= '0;
            prev_tag   <= '0;
            have_cur   <= 1'b0;
            seeded     <= 1'b0;
            frame_tag  <= '0;
            tag_valid  <= 1'b0;
            last_pix   <= '0;
            last_lines <= '0;
            frame_done <= 1'b0;
            err_tag    <= 1'b0;
            err_seq    <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            state      <= nxt;
            dout       <= din;
            href_q     <= href;
            vsync_q    <= vsync;
            pix_cnt    <= href ? (ls ? 11'd1 : inc) : pix_cnt;
            line_cnt   <= fs ? 10'd0 : lc_eff;
            line_tag   <= (tag_pix & idx == 11'd0) ? din[9:2] : line_tag;
            cur_tag    <= cur_eff;
            have_cur   <= ~fs & (have_cur | good_le);
            last_pix   <= do_le ? len : last_pix;
            frame_done <= do_fe;
            frame_tag  <= do_fe ? cur_eff : frame_tag;
            prev_tag   <= do_fe ? cur_eff : prev_tag;
            last_lines <= do_fe ? lc_eff : last_lines;
            tag_valid  <= tag_valid | do_fe;
            seeded     <= do_fe | (seeded & ~clr_err);
            err_tag    <= new_tag | (err_tag & ~clr_err);
            err_seq    <= new_seq | (err_seq & ~clr_err);
            err_len    <= new_len | (err_len & ~clr_err);
        end
    end
endmodule

// File: tb/tb_vp_tag_checker.sv
// tb_vp_tag_checker: randomized stream stimulus with a frame-level reference model.
// Expected frame results are queued by the driver and checked by a frame_done monitor.
module tb_vp_tag_checker;
    localparam int TL = 20, EP = 64, EL = 4;

    logic        vpclkin = 0, nReset = 0, href = 0, vsync = 0, clr_err = 0;
    logic [9:0]  din = 0;
    logic [9:0]  dout, last_lines;
    logic        href_o, vsync_o, tag_valid, frame_done, err_tag, err_seq, err_len;
    logic [7:0]  frame_tag;
    logic [10:0] last_pix;

    int checks = 0, errors = 0;

    typedef struct {
        logic [7:0]  tag;
        logic [10:0] lp;
        logic [9:0]  ll;
        logic        et, es, el;
    } exp_t;
    exp_t q[$];

    bit         in_frame = 0, have_tag = 0, m_seeded = 0, m_et = 0, m_es = 0, m_el = 0;
    int         n_lines = 0, last_len = 0;
    logic [7:0] first_tag = 0, m_prev = 0;

    vp_tag_checker #(.TAG_LEN(TL), .EXP_PIX(EP), .EXP_LINES(EL)) dut (
        .vpclkin(vpclkin), .nReset(nReset), .din(din), .href(href), .vsync(vsync),
        .clr_err(clr_err), .dout(dout), .href_o(href_o), .vsync_o(vsync_o),
        .frame_tag(frame_tag), .tag_valid(tag_valid), .last_pix(last_pix),
        .last_lines(last_lines), .frame_done(frame_done), .err_tag(err_tag),
        .err_seq(err_seq), .err_len(err_len)
    );

    always #5 vpclkin = ~vpclkin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // scoreboard: one queued expectation per frame_done pulse
    always @(negedge vpclkin) if (nReset && frame_done) begin
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_done: got unexpected pulse expected none");
        end else begin
            e = q.pop_front();
            chk("frame_tag", frame_tag, e.tag);
            chk("last_pix_frame", last_pix, e.lp);
            chk("last_lines", last_lines, e.ll);
            chk("err_tag", err_tag, e.et);
            chk("err_seq", err_seq, e.es);
            chk("err_len", err_len, e.el);
            chk("tag_valid", tag_valid, 1);
        end
    end

    logic [11:0] pd;
    logic        pv = 0;
    always @(posedge vpclkin) begin
        pd <= {din, href, vsync};
        pv <= nReset;
    end
    always @(negedge vpclkin) if (nReset && pv) chk("pipe", {dout, href_o, vsync_o}, pd);

    task automatic tick;
        @(posedge vpclkin);
        #1;
    endtask

    function automatic void m_frame_start;
        exp_t e;
        if (in_frame && n_lines > 0) begin
            if (n_lines != EL) m_el = 1;
            if (m_seeded && first_tag != 8'(m_prev + 8'd1)) m_es = 1;
            e.tag = first_tag;
            e.lp  = 11'(last_len);
            e.ll  = 10'(n_lines);
            e.et  = m_et;
            e.es  = m_es;
            e.el  = m_el;
            q.push_back(e);
            m_prev   = first_tag;
            m_seeded = 1;
        end
        in_frame = 1;
        n_lines  = 0;
        have_tag = 0;
    endfunction

    task automatic send_line(input int len, input logic [7:0] t, input int bp,
                             input logic [9:0] bv, input bit vs_end);
        logic [9:0] px [0:127];
        for (int i = 0; i < len; i++) px[i] = (i == bp) ? bv : (i < TL) ? {t, 2'b00} : 10'($urandom);
        for (int i = 0; i < len; i++) begin
            tick;
            href = 1;
            din  = px[i];
            if (vs_end && i == len - 1) vsync = 1;
        end
        if (in_frame) begin
            for (int i = 0; i < len && i < TL; i++)
                if (px[i][1:0] != 2'b00 || (i > 0 && px[i][9:2] != px[0][9:2])) m_et = 1;
            if (len < TL) m_el = 1;
            else if (!have_tag) begin
                first_tag = px[0][9:2];
                have_tag  = 1;
            end else if (px[0][9:2] != first_tag) m_et = 1;
            if (len != EP) m_el = 1;
            if (n_lines < 1023) n_lines++;
            last_len = len;
        end
        if (vs_end) m_frame_start();
        tick;
        href = 0;
        din  = 0;
        if (vs_end) begin
            tick;
            vsync = 0;
        end else begin
            tick;
            chk("last_pix_line", last_pix, in_frame ? len : 0);
        end
        repeat ($urandom_range(1, 4)) tick;
    endtask

    task automatic vsync_pulse;
        tick;
        vsync = 1;
        m_frame_start();
        repeat (2) tick;
        vsync = 0;
        repeat (2) tick;
    endtask

    task automatic frame_lines(input logic [7:0] t, input int n);
        for (int l = 0; l < n; l++) send_line(EP, t, -1, 10'd0, 0);
        vsync_pulse();
    endtask

    task automatic clear;
        tick;
        clr_err = 1;
        m_et = 0;
        m_es = 0;
        m_el = 0;
        m_seeded = 0;
        tick;
        clr_err = 0;
        chk("clr_err_tag", err_tag, 0);
        chk("clr_err_seq", err_seq, 0);
        chk("clr_err_len", err_len, 0);
    endtask

    task automatic zero_checks;
        chk("rst_dout", dout, 0);
        chk("rst_href_o", href_o, 0);
        chk("rst_vsync_o", vsync_o, 0);
        chk("rst_frame_tag", frame_tag, 0);
        chk("rst_tag_valid", tag_valid, 0);
        chk("rst_last_pix", last_pix, 0);
        chk("rst_last_lines", last_lines, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_tag", err_tag, 0);
        chk("rst_err_seq", err_seq, 0);
        chk("rst_err_len", err_len, 0);
    endtask

    initial begin
        logic [7:0] t, lt;
        int nl, len, bp;
        repeat (3) tick;
        zero_checks();
        nReset = 1;
        repeat (2) tick;
        vsync_pulse();
        frame_lines(8'h10, 4);
        frame_lines(8'h11, 4);
        frame_lines(8'h12, 4);
        frame_lines(8'h10, 4);
        frame_lines(8'h12, 4);
        clear();
        frame_lines(8'h13, 4);
        frame_lines(8'h14, 4);
        clear();
        for (int l = 0; l < 4; l++) send_line(EP, 8'h11, (l == 1) ? 7 : -1, {8'h11, 2'b01}, 0);
        vsync_pulse();
        clear();
        for (int l = 0; l < 4; l++) send_line(EP, (l == 2) ? 8'h55 : 8'h11, -1, 10'd0, 0);
        vsync_pulse();
        clear();
        for (int l = 0; l < 5; l++) send_line((l == 2) ? 60 : EP, 8'h12, -1, 10'd0, 0);
        vsync_pulse();
        clear();
        frame_lines(8'hFF, 4);
        for (int l = 0; l < 4; l++) send_line(EP, 8'h00, -1, 10'd0, l == 3);
        repeat (3) tick;
        vsync_pulse();
        tick;
        href = 1;
        for (int i = 0; i < 30; i++) begin
            din = 10'($urandom);
            tick;
        end
        #3 nReset = 0;
        #1 zero_checks();
        m_et = 0;
        m_es = 0;
        m_el = 0;
        m_seeded = 0;
        in_frame = 0;
        n_lines = 0;
        have_tag = 0;
        tick;
        href = 0;
        din  = 0;
        tick;
        nReset = 1;
        repeat (2) tick;
        send_line(EP, 8'h77, -1, 10'd0, 0);
        vsync_pulse();
        frame_lines(8'h40, 4);
        t = 8'h20;
        for (int f = 0; f < 14; f++) begin
            nl = $urandom_range(3, 5);
            if ($urandom_range(0, 5) == 0) clear();
            t = ($urandom_range(0, 4) == 0) ? 8'($urandom) : t + 8'd1;
            for (int l = 0; l < nl; l++) begin
                len = (l > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, 100) : EP;
                bp  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 25) : -1;
                lt  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : t;
                send_line(len, lt, bp, 10'($urandom), 0);
            end
            vsync_pulse();
        end
        for (int i = 0; i < 50 && q.size() != 0; i++) tick;
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
